// File: rtl/lvds_frame_gen.sv
// Multi-lane framed test-pattern source feeding per-lane 8b/10b encoders ahead of the LVDS serialisers.
// Build option FRAME_CRC_EN appends a per-lane CRC-8 byte after the payload.
module lvds_frame_gen #(
    parameter int         LANES       = 1,
    parameter int         PAYLOAD_LEN = 125,
    parameter int         GAP_LEN     = 573,
    parameter logic [7:0] HDR0        = 8'hEE,
    parameter logic [7:0] HDR1        = 8'h33,
    parameter logic [7:0] IDLE_K      = 8'hBC,
    parameter logic [7:0] PAY_SEED    = 8'h34
) (
    input  logic                 sys_clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [1:0]           mode,
    output logic [8*LANES-1:0]   data_out,
    output logic [LANES-1:0]     k_out,
    output logic                 sof,
    output logic                 eof,
    output logic                 pay_valid,
    output logic                 busy,
    output logic [15:0]          frame_cnt
);

    localparam int CNT_MAX = (PAYLOAD_LEN > GAP_LEN) ? PAYLOAD_LEN : GAP_LEN;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] LAST_PAY = CNT_W'(PAYLOAD_LEN - 1);
    localparam logic [CNT_W-1:0] LAST_GAP = CNT_W'(GAP_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR0,
        S_HDR1,
        S_PAY,
`ifdef FRAME_CRC_EN
        S_CRC,
`endif
        S_GAP
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [8*LANES-1:0] data_q, data_d;
    logic [LANES-1:0]   k_q, k_d;
    logic               sof_q, sof_d, eof_q, eof_d, pv_q, pv_d, busy_q, busy_d;
    logic [15:0]        fcnt_q, fcnt_d;
    logic [1:0]         mode_q, mode_d;
    logic [6:0]         lfsr_q [LANES];
    logic [6:0]         lfsr_d [LANES];
    logic [14:0]        prbs_v;
    logic [7:0]         pb_v;
`ifdef FRAME_CRC_EN
    logic [7:0]         crc_q [LANES];
    logic [7:0]         crc_d [LANES];
`endif

    function automatic logic [7:0] crc8_upd(input logic [7:0] crc, input logic [7:0] din);
        logic [7:0] c;
        c = crc ^ din;
        for (int b = 0; b < 8; b++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

    // Eight PRBS7 (x^7+x^6+1) steps; returns {next_state, byte}, first bit in the MSB.
    function automatic logic [14:0] prbs7_step8(input logic [6:0] s_in);
        logic [6:0] s;
        logic [7:0] b;
        logic       fb;
        s = s_in;
        b = '0;
        for (int k = 0; k < 8; k++) begin
            fb = s[6] ^ s[5];
            s  = {s[5:0], fb};
            b  = {b[6:0], fb};
        end
        return {s, b};
    endfunction

    function automatic logic [7:0] pay_byte(input logic [1:0] m, input logic [7:0] lane,
                                            input logic [CNT_W-1:0] n, input logic [7:0] prbs);
        logic [7:0] s;
        s = 8'(n) + lane;
        case (m)
            2'd0:    return PAY_SEED + s;
            2'd1:    return prbs;
            2'd2:    return 8'h55;
            default: return 8'h01 << s[2:0];
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: if (en) state_d = S_HDR0;
            S_HDR0: state_d = S_HDR1;
            S_HDR1: begin
                state_d = S_PAY;
                cnt_d   = '0;
            end
            S_PAY: begin
                if (cnt_q == LAST_PAY) begin
`ifdef FRAME_CRC_EN
                    state_d = S_CRC;
`else
                    state_d = S_GAP;
`endif
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef FRAME_CRC_EN
            S_CRC: begin
                state_d = S_GAP;
                cnt_d   = '0;
            end
`endif
            S_GAP: begin
                if (cnt_q == LAST_GAP) begin
                    state_d = en ? S_HDR0 : S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are computed for the state being entered so they register alongside it.
    always_comb begin
        mode_d = mode_q;
        lfsr_d = lfsr_q;
        prbs_v = '0;
        pb_v   = '0;
        data_d = {LANES{IDLE_K}};
        k_d    = '1;
        sof_d  = 1'b0;
        eof_d  = 1'b0;
        pv_d   = 1'b0;
        busy_d = 1'b0;
        fcnt_d = fcnt_q;
`ifdef FRAME_CRC_EN
        crc_d  = crc_q;
`endif
        case (state_d)
            S_HDR0: begin
                data_d = {LANES{HDR0}};
                k_d    = '0;
                sof_d  = 1'b1;
                busy_d = 1'b1;
                mode_d = mode;
                for (int i = 0; i < LANES; i++) begin
                    lfsr_d[i] = 7'(i + 1);
`ifdef FRAME_CRC_EN
                    crc_d[i] = crc8_upd(8'h00, HDR0);
`endif
                end
            end
            S_HDR1: begin
                data_d = {LANES{HDR1}};
                k_d    = '0;
                busy_d = 1'b1;
`ifdef FRAME_CRC_EN
                for (int i = 0; i < LANES; i++) crc_d[i] = crc8_upd(crc_q[i], HDR1);
`endif
            end
            S_PAY: begin
                k_d    = '0;
                pv_d   = 1'b1;
                busy_d = 1'b1;
                for (int i = 0; i < LANES; i++) begin
                    prbs_v    = prbs7_step8(lfsr_q[i]);
                    lfsr_d[i] = prbs_v[14:8];
                    pb_v      = pay_byte(mode_q, 8'(i), cnt_d, prbs_v[7:0]);
                    data_d[8*i +: 8] = pb_v;
`ifdef FRAME_CRC_EN
                    crc_d[i] = crc8_upd(crc_q[i], pb_v);
`endif
                end
`ifndef FRAME_CRC_EN
                if (cnt_d == LAST_PAY) begin
                    eof_d  = 1'b1;
                    fcnt_d = fcnt_q + 16'd1;
                end
`endif
            end
`ifdef FRAME_CRC_EN
            S_CRC: begin
                for (int i = 0; i < LANES; i++) data_d[8*i +: 8] = crc_q[i];
                k_d    = '0;
                busy_d = 1'b1;
                eof_d  = 1'b1;
                fcnt_d = fcnt_q + 16'd1;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            data_q  <= {LANES{IDLE_K}};
            k_q     <= '1;
            sof_q   <= 1'b0;
            eof_q   <= 1'b0;
            pv_q    <= 1'b0;
            busy_q  <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            k_q     <= k_d;
            sof_q   <= sof_d;
            eof_q   <= eof_d;
            pv_q    <= pv_d;
            busy_q  <= busy_d;
            fcnt_q  <= fcnt_d;
        end
    end

    // Pattern state is reloaded at every HDR0, so it needs no reset.
    always_ff @(posedge sys_clk) begin
        mode_q <= mode_d;
        lfsr_q <= lfsr_d;
`ifdef FRAME_CRC_EN
        crc_q  <= crc_d;
`endif
    end

    assign data_out  = data_q;
    assign k_out     = k_q;
    assign sof       = sof_q;
    assign eof       = eof_q;
    assign pay_valid = pv_q;
    assign busy      = busy_q;
    assign frame_cnt = fcnt_q;

endmodule

// File: tb/tb_lvds_frame_gen.sv
// Randomised bench for lvds_frame_gen against a frame-level reference model (queue of expected cycles).
module tb_lvds_frame_gen;

    localparam int LANES = 2;
`ifdef FRAME_CRC_EN
    localparam int         PL     = 3;
    localparam logic [7:0] SEED   = 8'h01;
    localparam bit         CRC_ON = 1'b1;
`else
    localparam int         PL     = 300;
    localparam logic [7:0] SEED   = 8'h34;
    localparam bit         CRC_ON = 1'b0;
`endif
    localparam int         GL     = 573;
    localparam logic [7:0] HDR0_B = 8'hEE;
    localparam logic [7:0] HDR1_B = 8'h33;
    localparam logic [7:0] IDLE_B = 8'hBC;
    localparam int         PERIOD = 2 + PL + GL + (CRC_ON ? 1 : 0);

    logic                 sys_clk = 1'b0;
    logic                 rst_n   = 1'b0;
    logic                 en      = 1'b0;
    logic [1:0]           mode    = 2'd0;
    logic [8*LANES-1:0]   data_out;
    logic [LANES-1:0]     k_out;
    logic                 sof, eof, pay_valid, busy;
    logic [15:0]          frame_cnt;

    always #5 sys_clk = ~sys_clk;

    lvds_frame_gen #(
        .LANES(LANES), .PAYLOAD_LEN(PL), .GAP_LEN(GL), .PAY_SEED(SEED)
    ) dut (
        .sys_clk(sys_clk), .rst_n(rst_n), .en(en), .mode(mode),
        .data_out(data_out), .k_out(k_out), .sof(sof), .eof(eof),
        .pay_valid(pay_valid), .busy(busy), .frame_cnt(frame_cnt)
    );

    // One expected output cycle; fl = {sof, eof, pay_valid, busy}.
    typedef struct {
        logic [8*LANES-1:0] d;
        logic [LANES-1:0]   k;
        logic [3:0]         fl;
    } rec_t;

    rec_t        q[$];
    rec_t        cur;
    logic [15:0] fc_exp = '0;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic rec_t idle_rec();
        rec_t r;
        r.d  = {LANES{IDLE_B}};
        r.k  = '1;
        r.fl = 4'b0000;
        return r;
    endfunction

    function automatic logic [7:0] ref_crc8(input logic [7:0] crc, input logic [7:0] din);
        logic [7:0] c;
        c = crc;
        for (int b = 7; b >= 0; b--) begin
            if (c[7] ^ din[b]) c = (c << 1) ^ 8'h07;
            else               c = c << 1;
        end
        return c;
    endfunction

    // Queue one whole frame plus its gap, built from the pattern rules.
    task automatic push_frame(input logic [1:0] m);
        rec_t       r;
        logic [7:0] pay [LANES][PL];
        logic [7:0] crc;
        bit         a[];
        for (int l = 0; l < LANES; l++) begin
            logic [6:0] seed;
            seed = 7'(l + 1);
            a = new[7 + 8*PL];
            for (int j = 0; j < 7; j++) a[j] = seed[6-j];
            for (int j = 7; j < 7 + 8*PL; j++) a[j] = a[j-7] ^ a[j-6];
            for (int n = 0; n < PL; n++) begin
                logic [7:0] b;
                case (m)
                    2'd0:    b = 8'(SEED + l + n);
                    2'd1:    for (int t = 0; t < 8; t++) b[7-t] = a[7 + 8*n + t];
                    2'd2:    b = 8'h55;
                    default: b = 8'(1 << ((n + l) % 8));
                endcase
                pay[l][n] = b;
            end
        end
        r.k  = '0;
        r.d  = {LANES{HDR0_B}};
        r.fl = 4'b1001;
        q.push_back(r);
        r.d  = {LANES{HDR1_B}};
        r.fl = 4'b0001;
        q.push_back(r);
        for (int n = 0; n < PL; n++) begin
            for (int l = 0; l < LANES; l++) r.d[8*l +: 8] = pay[l][n];
            r.fl = {1'b0, (n == PL - 1) && !CRC_ON, 2'b11};
            q.push_back(r);
        end
`ifdef FRAME_CRC_EN
        for (int l = 0; l < LANES; l++) begin
            crc = ref_crc8(8'h00, HDR0_B);
            crc = ref_crc8(crc, HDR1_B);
            for (int n = 0; n < PL; n++) crc = ref_crc8(crc, pay[l][n]);
            r.d[8*l +: 8] = crc;
        end
        r.fl = 4'b0101;
        q.push_back(r);
`endif
        repeat (GL) q.push_back(idle_rec());
    endtask

    // Checks every cycle on the falling edge, then predicts the next cycle from en/mode.
    initial begin
        rec_t nxt;
        cur = idle_rec();
        forever begin
            @(negedge sys_clk);
            if (!rst_n) begin
                q.delete();
                cur    = idle_rec();
                fc_exp = '0;
            end
            check_eq("data_out", 64'(data_out), 64'(cur.d));
            check_eq("k_out", 64'(k_out), 64'(cur.k));
            check_eq("flags", 64'({sof, eof, pay_valid, busy}), 64'(cur.fl));
            check_eq("frame_cnt", 64'(frame_cnt), 64'(fc_exp));
            if (rst_n && q.size() == 0 && en) push_frame(mode);
            if (rst_n && q.size() > 0) nxt = q.pop_front();
            else                       nxt = idle_rec();
            if (nxt.fl[2]) fc_exp = fc_exp + 16'd1;
            cur = nxt;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #2;
        end
    endtask

    task automatic wait_sof(input string tag);
        int i;
        i = 0;
        tick(1);
        while (!sof && i < 2*PERIOD + 10) begin
            tick(1);
            i++;
        end
        check_eq(tag, 64'(sof), 64'd1);
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_data"}, 64'(data_out), 64'({LANES{IDLE_B}}));
        check_eq({tag, "_k"}, 64'(k_out), 64'({LANES{1'b1}}));
        check_eq({tag, "_flags"}, 64'({sof, eof, pay_valid, busy}), 64'd0);
        check_eq({tag, "_fcnt"}, 64'(frame_cnt), 64'd0);
    endtask

    initial begin
        int cnt;
        int nsof;
        tick(3);
        check_reset_vals("reset");
        rst_n = 1'b1;
        tick(3);
        en   = 1'b1;
        mode = 2'd0;

`ifndef FRAME_CRC_EN
        // Legacy stream end on lane 0 and the 0xFF->0x00 wrap.
        wait_sof("sof_first");
        tick(2 + 124);
        check_eq("pay124_l0", 64'(data_out[7:0]), 64'h B0);
        check_eq("pay124_l1", 64'(data_out[15:8]), 64'h B1);
        tick(80);
        check_eq("wrap_l0", 64'(data_out[7:0]), 64'h00);
        check_eq("wrap_k", 64'(k_out), 64'd0);
`endif

        // Frame period, with a mid-payload mode change that must wait for the next frame.
        wait_sof("sof_period");
        cnt = 0;
        do begin
            tick(1);
            cnt++;
            if (cnt == 2 + PL/2) mode = 2'd2;
        end while (!sof && cnt < 3*PERIOD);
        check_eq("period", 64'(cnt), 64'(PERIOD));
        tick(2);
        check_eq("const55", 64'(data_out[7:0]), 64'h55);

        // Two PRBS frames back to back, then randomised modes with ignored mid-frame changes.
        mode = 2'd1;
        wait_sof("sof_prbs0");
        wait_sof("sof_prbs1");
        for (int f = 0; f < 4; f++) begin
            mode = 2'($urandom_range(0, 3));
            wait_sof("sof_rand");
            tick($urandom_range(1, PL));
            mode = 2'($urandom);
        end

        // en dropped inside payload: frame and gap finish, then no further frame.
        wait_sof("sof_drop");
        tick(2 + ((PL > 10) ? 10 : 1));
        en   = 1'b0;
        nsof = 0;
        for (int i = 0; i < PERIOD + 100; i++) begin
            tick(1);
            if (sof) nsof++;
        end
        check_eq("no_sof_after_drop", 64'(nsof), 64'd0);
        check_eq("idle_busy", 64'(busy), 64'd0);

        en   = 1'b1;
        mode = 2'd0;
        wait_sof("sof_final");
`ifdef FRAME_CRC_EN
        tick(2 + PL);
        check_eq("crc_eof", 64'(eof), 64'd1);
        check_eq("crc_pv", 64'(pay_valid), 64'd0);
        check_eq("crc_k", 64'(k_out), 64'd0);
        wait_sof("sof_crc_next");
`endif
        // Asynchronous reset in the middle of the payload.
        tick(2 + PL/2);
        rst_n = 1'b0;
        #1;
        check_reset_vals("async_rst");
        tick(1);
        rst_n = 1'b1;
        tick(PERIOD + 20);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
